// File: rtl/clock_time_counter.sv
// Wall-clock time-of-day counter (24 h) driven by a one-second tick.
// Supports a range-checked front-panel load, a pause control, and carry/day pulses.
module clock_time_counter #(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tick,
    input  logic                  i_run_en,
    input  logic                  i_load,
    input  logic [P_SEC_BIT-1:0]  i_load_sec,
    input  logic [P_MIN_BIT-1:0]  i_load_min,
    input  logic [P_HOUR_BIT-1:0] i_load_hour,
    output logic [P_SEC_BIT-1:0]  sec,
    output logic [P_MIN_BIT-1:0]  minute,
    output logic [P_HOUR_BIT-1:0] hour,
    output logic                  o_min_tick,
    output logic                  o_hour_tick,
    output logic                  o_day_tick,
    output logic                  o_load_ack,
    output logic                  o_load_err
);

    localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);

    logic load_valid;
    logic count_step;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign load_valid = (i_load_sec <= SEC_MAX) && (i_load_min <= MIN_MAX)
                        && (i_load_hour <= HOUR_MAX);
    assign count_step = i_run_en && i_tick;
    assign sec_wrap   = (sec == SEC_MAX);
    assign min_wrap   = sec_wrap && (minute == MIN_MAX);
    assign hour_wrap  = min_wrap && (hour == HOUR_MAX);

    // A valid load takes priority over a coincident tick; a rejected load lets the tick through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec         <= '0;
            minute      <= '0;
            hour        <= '0;
            o_min_tick  <= 1'b0;
            o_hour_tick <= 1'b0;
            o_day_tick  <= 1'b0;
            o_load_ack  <= 1'b0;
            o_load_err  <= 1'b0;
        end else begin
            o_min_tick  <= 1'b0;
            o_hour_tick <= 1'b0;
            o_day_tick  <= 1'b0;
            o_load_ack  <= 1'b0;
            o_load_err  <= 1'b0;
            if (i_load && load_valid) begin
                sec        <= i_load_sec;
                minute     <= i_load_min;
                hour       <= i_load_hour;
                o_load_ack <= 1'b1;
            end else begin
                if (i_load) begin
                    o_load_err <= 1'b1;
                end
                if (count_step) begin
                    sec <= sec_wrap ? '0 : sec + P_SEC_BIT'(1);
                    if (sec_wrap) begin
                        o_min_tick <= 1'b1;
                        minute     <= min_wrap ? '0 : minute + P_MIN_BIT'(1);
                    end
                    if (min_wrap) begin
                        o_hour_tick <= 1'b1;
                        hour        <= hour_wrap ? '0 : hour + P_HOUR_BIT'(1);
                    end
                    if (hour_wrap) begin
                        o_day_tick <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed-vector bench for clock_time_counter: table of single-cycle vectors
// followed by hand-written sequences for tick spacing, pause and async reset.
module tb_clock_time_counter;

    logic       clk;
    logic       reset;
    logic       i_tick;
    logic       i_run_en;
    logic       i_load;
    logic [5:0] i_load_sec;
    logic [5:0] i_load_min;
    logic [4:0] i_load_hour;
    logic [5:0] sec;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       o_min_tick;
    logic       o_hour_tick;
    logic       o_day_tick;
    logic       o_load_ack;
    logic       o_load_err;

    int vectors_applied = 0;
    int miscompares     = 0;

    clock_time_counter dut (
        .clk         (clk),
        .reset       (reset),
        .i_tick      (i_tick),
        .i_run_en    (i_run_en),
        .i_load      (i_load),
        .i_load_sec  (i_load_sec),
        .i_load_min  (i_load_min),
        .i_load_hour (i_load_hour),
        .sec         (sec),
        .minute      (minute),
        .hour        (hour),
        .o_min_tick  (o_min_tick),
        .o_hour_tick (o_hour_tick),
        .o_day_tick  (o_day_tick),
        .o_load_ack  (o_load_ack),
        .o_load_err  (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run_en;
        logic       tick;
        logic       load;
        logic [4:0] lh;
        logic [5:0] lm;
        logic [5:0] ls;
        logic [4:0] eh;
        logic [5:0] em;
        logic [5:0] es;
        logic [4:0] epulse;   // {min_tick, hour_tick, day_tick, ack, err}
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic run_en, input logic tick, input logic load,
                                input int lh, input int lm, input int ls,
                                input int eh, input int em, input int es,
                                input logic [4:0] epulse);
        vec_t v;
        v.run_en = run_en;
        v.tick   = tick;
        v.load   = load;
        v.lh     = 5'(lh);
        v.lm     = 6'(lm);
        v.ls     = 6'(ls);
        v.eh     = 5'(eh);
        v.em     = 6'(em);
        v.es     = 6'(es);
        v.epulse = epulse;
        return v;
    endfunction

    task automatic apply_stimulus(input logic run_en, input logic tick, input logic load,
                                  input int lh, input int lm, input int ls);
        i_run_en    = run_en;
        i_tick      = tick;
        i_load      = load;
        i_load_hour = 5'(lh);
        i_load_min  = 6'(lm);
        i_load_sec  = 6'(ls);
        @(posedge clk);
        #1;
        i_tick = 1'b0;
        i_load = 1'b0;
    endtask

    task automatic check_output(input string name, input int eh, input int em, input int es,
                                input logic [4:0] epulse);
        logic [4:0] act_pulse;
        act_pulse = {o_min_tick, o_hour_tick, o_day_tick, o_load_ack, o_load_err};
        vectors_applied++;
        if (hour !== 5'(eh) || minute !== 6'(em) || sec !== 6'(es) || act_pulse !== epulse) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d:%0d:%0d pulses=%b, expected %0d:%0d:%0d pulses=%b",
                     name, hour, minute, sec, act_pulse, eh, em, es, epulse);
        end
    endtask

    initial begin
        // pulse order: {min_tick, hour_tick, day_tick, ack, err}
        vecs[0]  = mk(1, 0, 0,  0,  0,  0,   0,  0,  0, 5'b00000);
        vecs[1]  = mk(1, 0, 1,  0,  0, 58,   0,  0, 58, 5'b00010);
        vecs[2]  = mk(1, 0, 0,  0,  0,  0,   0,  0, 58, 5'b00000);
        vecs[3]  = mk(1, 1, 0,  0,  0,  0,   0,  0, 59, 5'b00000);
        vecs[4]  = mk(1, 1, 0,  0,  0,  0,   0,  1,  0, 5'b10000);
        vecs[5]  = mk(1, 0, 0,  0,  0,  0,   0,  1,  0, 5'b00000);
        vecs[6]  = mk(1, 0, 1, 23, 59, 59,  23, 59, 59, 5'b00010);
        vecs[7]  = mk(1, 1, 0,  0,  0,  0,   0,  0,  0, 5'b11100);
        vecs[8]  = mk(1, 0, 0,  0,  0,  0,   0,  0,  0, 5'b00000);
        vecs[9]  = mk(1, 0, 1, 12, 60,  0,   0,  0,  0, 5'b00001);
        vecs[10] = mk(1, 0, 1, 24,  0,  0,   0,  0,  0, 5'b00001);
        vecs[11] = mk(1, 0, 1, 23, 59, 59,  23, 59, 59, 5'b00010);
        vecs[12] = mk(1, 0, 1, 10, 20, 30,  10, 20, 30, 5'b00010);
        vecs[13] = mk(1, 1, 1, 11,  0,  0,  11,  0,  0, 5'b00010);
        vecs[14] = mk(1, 1, 0,  0,  0,  0,  11,  0,  1, 5'b00000);
        vecs[15] = mk(1, 1, 1, 12, 60,  0,  11,  0,  2, 5'b00001);
        vecs[16] = mk(1, 0, 1,  0,  0, 60,  11,  0,  2, 5'b00001);
        vecs[17] = mk(0, 1, 0,  0,  0,  0,  11,  0,  2, 5'b00000);
        vecs[18] = mk(0, 0, 1,  0, 59, 59,   0, 59, 59, 5'b00010);
        vecs[19] = mk(0, 1, 0,  0,  0,  0,   0, 59, 59, 5'b00000);
        vecs[20] = mk(1, 1, 0,  0,  0,  0,   1,  0,  0, 5'b11000);
        vecs[21] = mk(1, 1, 0,  0,  0,  0,   1,  0,  1, 5'b00000);

        reset = 1'b0;
        i_run_en = 1'b0;
        i_tick = 1'b0;
        i_load = 1'b0;
        i_load_sec = '0;
        i_load_min = '0;
        i_load_hour = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("in_reset", 0, 0, 0, 5'b00000);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].run_en, vecs[i].tick, vecs[i].load,
                           int'(vecs[i].lh), int'(vecs[i].lm), int'(vecs[i].ls));
            check_output($sformatf("vec%0d", i), int'(vecs[i].eh), int'(vecs[i].em),
                         int'(vecs[i].es), vecs[i].epulse);
        end

        // Two ticks ten cycles apart, time must hold in between.
        apply_stimulus(1, 0, 1, 0, 0, 58);
        check_output("space_load", 0, 0, 58, 5'b00010);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("space_tick1", 0, 0, 59, 5'b00000);
        for (int k = 0; k < 9; k++) begin
            apply_stimulus(1, 0, 0, 0, 0, 0);
            check_output($sformatf("space_idle%0d", k), 0, 0, 59, 5'b00000);
        end
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("space_tick2", 0, 1, 0, 5'b10000);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("space_after", 0, 1, 0, 5'b00000);

        // Paused: five ticks dropped, then one tick advances by exactly one.
        apply_stimulus(1, 0, 1, 1, 2, 3);
        check_output("pause_load", 1, 2, 3, 5'b00010);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, 1, 0, 0, 0, 0);
            check_output($sformatf("pause_tick%0d", k), 1, 2, 3, 5'b00000);
        end
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("resume_tick", 1, 2, 4, 5'b00000);

        // Asynchronous reset while the load-ack pulse is still high.
        apply_stimulus(1, 0, 1, 5, 6, 7);
        check_output("pre_reset", 5, 6, 7, 5'b00010);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset", 0, 0, 0, 5'b00000);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("post_reset_tick", 0, 0, 1, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Downstream stage of the one-second tick generator. Consumes its single-cycle one-second tick and maintains the wall-clock time as registered sec / minute / hour outputs (24 h format).
- Provides a validated synchronous time-load port for the front panel, a pause control, and carry/day-rollover pulses for later alarm and date blocks.

Parameters:
- P_SEC_BIT, 6, width of seconds field (range 0..59)
- P_MIN_BIT, 6, width of minutes field (range 0..59)
- P_HOUR_BIT, 5, width of hours field (range 0..23)

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- i_tick  input  1  one-second tick, one clk cycle wide, from tick generator
- i_run_en  input  1  1 = count ticks; 0 = hold time, ticks ignored
- i_load  input  1  single-cycle load strobe
- i_load_sec  input  P_SEC_BIT  seconds value to load
- i_load_min  input  P_MIN_BIT  minutes value to load
- i_load_hour  input  P_HOUR_BIT  hours value to load
- sec  output  P_SEC_BIT  current seconds, registered
- minute  output  P_MIN_BIT  current minutes, registered
- hour  output  P_HOUR_BIT  current hours, registered
- o_min_tick  output  1  1-cycle pulse when seconds wrap 59->0
- o_hour_tick  output  1  1-cycle pulse when minutes wrap 59->0
- o_day_tick  output  1  1-cycle pulse when time wraps 23:59:59->00:00:00
- o_load_ack  output  1  1-cycle pulse: load accepted
- o_load_err  output  1  1-cycle pulse: load rejected (out of range)

Behaviour:
- Reset (reset=0, asynchronous): sec=0, minute=0, hour=0. All pulse outputs 0. Release is synchronous to clk.
- Count (i_run_en=1, i_tick=1, no i_load): outputs update on the same posedge that samples the tick, so they are visible the following cycle. Latency is 1 cycle.
  - sec<59: sec+1.
  - sec=59: sec=0, minute+1, o_min_tick=1.
  - minute=59 with seconds wrap: minute=0, hour+1, o_hour_tick=1.
  - hour=23 with minutes wrap: hour=0, o_day_tick=1.
  - A full wrap 23:59:59->00:00:00 asserts all three pulses in the same cycle.
- Pulse outputs are registered and high for exactly 1 cycle. They are 0 in every cycle without a carry.
- i_run_en=0: time holds and ticks are dropped, not queued. Load is still honoured.
- Load (i_load=1), independent of i_run_en:
  - Valid iff i_load_sec<=59, i_load_min<=59 and i_load_hour<=23.
  - Valid load: all three fields are written on the next posedge and o_load_ack=1 for 1 cycle.
  - Invalid load: time is unchanged, o_load_err=1 for 1 cycle, and any coincident tick is still applied.
- Simultaneous valid load and tick: load wins. The tick is discarded and no carry pulses are generated that cycle.
- i_load held high for N cycles: each cycle is treated as an independent load.
- Counters never leave their legal ranges. All internal compares are against constants 59/23, never against field width.
- Arithmetic is unsigned. Increments are computed at field width, with the wrap decided by the compare, not by overflow.
- Reset asserted mid-count or mid-load overrides everything immediately, including any pending pulse.
- No internal combinational path from inputs to outputs.

Test Plan:
- Reset then 0 ticks -> sec/minute/hour=0, all pulses 0. Assert reset mid-run at 05:06:07 -> outputs 00:00:00 before the next clk edge.
- Load 00:00:58, run_en=1, two ticks spaced 10 cycles apart -> 00:00:59, then 00:01:00 with o_min_tick high exactly 1 cycle, o_hour_tick=0.
- Load 23:59:59, one tick -> 00:00:00 with o_min_tick, o_hour_tick and o_day_tick all high in the same single cycle.
- Load 12:60:00 -> o_load_err=1 for 1 cycle, time unchanged. Load 24:00:00 -> error. Load 23:59:59 -> o_load_ack=1, time 23:59:59.
- From 10:20:30, assert i_load (11:00:00) and i_tick in the same cycle -> 11:00:00, no carry pulses. The next tick -> 11:00:01.
- run_en=0 at 01:02:03 with 5 ticks -> time stays 01:02:03. Set run_en=1 and apply 1 tick -> 01:02:04 (dropped ticks not replayed).
